// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared FSM state encoding and owner id encoding for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin pick; ties go to the port
//               that was not served last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = OWN_A;
        case (req)
            2'b10:   grant = OWN_B;
            2'b11:   grant = (last == OWN_A) ? OWN_B : OWN_A;
            default: grant = OWN_A;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (CPU A / IO B) arbiter onto a single-port synchronous
//               memory; one access per four cycles, round-robin on ties.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_we;
    logic                  r_owner;
    logic                  r_last;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_a_ack;
    logic                  r_b_ack;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;

    logic                  w_grant;
    logic                  w_valid;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    rr_arbiter2 u_rr (
        .req   ({b_req, a_req}),
        .last  (r_last),
        .grant (w_grant),
        .valid (w_valid)
    );

    always_comb begin
        w_sel_we    = (w_grant == OWN_B) ? b_we    : a_we;
        w_sel_addr  = (w_grant == OWN_B) ? b_addr  : a_addr;
        w_sel_wdata = (w_grant == OWN_B) ? b_wdata : a_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_valid ? ACCESS : IDLE;
            ACCESS:  w_state_next = WAIT;
            WAIT:    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request fields are captured once at grant; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_owner     <= OWN_A;
            r_last      <= OWN_B;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
        end else begin
            r_mem_we <= 1'b0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner     <= w_grant;
                        r_we        <= w_sel_we;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                WAIT: begin
                    if (!r_we) begin
                        if (r_owner == OWN_A) begin
                            r_a_rdata <= mem_q;
                        end else begin
                            r_b_rdata <= mem_q;
                        end
                    end
                    r_a_ack <= (r_owner == OWN_A);
                    r_b_ack <= (r_owner == OWN_B);
                end
                DONE: begin
                    r_last <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign a_ack     = r_a_ack;
    assign b_ack     = r_b_ack;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a 64-entry
//               one-cycle-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q;
    logic          busy;

    logic [DW-1:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_q <= mem[mem_addr];
    end

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_q     (mem_q),
        .busy      (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_req = 1'b1; a_we = 1'b1; a_addr = 6'h01; a_wdata = 16'h0001;
        tick(); tick();
        checks++;
        if ({busy, a_ack, b_ack} !== 3'b000) begin failures++;
            $display("FAIL reset_ctrl: got busy/a_ack/b_ack=%b expected 000", {busy, a_ack, b_ack}); end
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== '0) begin failures++;
            $display("FAIL reset_mem_cmd: got we=%b addr=%h wdata=%h expected all 0", mem_we, mem_addr, mem_wdata); end
        checks++;
        if ({a_rdata, b_rdata} !== '0) begin failures++;
            $display("FAIL reset_rdata: got a=%h b=%h expected 0", a_rdata, b_rdata); end
        a_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h05; a_wdata = 16'h1234;
        tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, busy} !== {1'b1, 6'h05, 16'h1234, 1'b1}) begin failures++;
            $display("FAIL wr_access: got we=%b addr=%h wdata=%h busy=%b expected 1 05 1234 1", mem_we, mem_addr, mem_wdata, busy); end
        tick();
        checks++;
        if ({mem_we, a_ack, b_ack, busy} !== 4'b0001) begin failures++;
            $display("FAIL wr_wait: got we/a_ack/b_ack/busy=%b expected 0001", {mem_we, a_ack, b_ack, busy}); end
        tick();
        checks++;
        if ({a_ack, b_ack, busy} !== 3'b101) begin failures++;
            $display("FAIL wr_done: got a_ack/b_ack/busy=%b expected 101", {a_ack, b_ack, busy}); end
        tick();
        checks++;
        if ({a_ack, b_ack, busy} !== 3'b000) begin failures++;
            $display("FAIL wr_idle: got a_ack/b_ack/busy=%b expected 000", {a_ack, b_ack, busy}); end
        checks++;
        if (mem[5] !== 16'h1234) begin failures++;
            $display("FAIL wr_mem: got %h expected 1234", mem[5]); end
        a_req = 1'b0;
    endtask

    task automatic test_read();
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05; a_wdata = 16'hFFFF;
        tick();
        checks++;
        if ({mem_we, mem_addr, busy} !== {1'b0, 6'h05, 1'b1}) begin failures++;
            $display("FAIL rd_access: got we=%b addr=%h busy=%b expected 0 05 1", mem_we, mem_addr, busy); end
        tick();
        checks++;
        if ({a_ack, busy} !== 2'b01) begin failures++;
            $display("FAIL rd_wait: got a_ack/busy=%b expected 01", {a_ack, busy}); end
        tick();
        checks++;
        if ({a_ack, b_ack, busy, a_rdata} !== {3'b101, 16'h1234}) begin failures++;
            $display("FAIL rd_done: got ack=%b%b busy=%b rdata=%h expected 1 0 1 1234", a_ack, b_ack, busy, a_rdata); end
        tick();
        checks++;
        if ({a_ack, busy, a_rdata} !== {2'b00, 16'h1234}) begin failures++;
            $display("FAIL rd_hold: got a_ack=%b busy=%b rdata=%h expected 0 0 1234", a_ack, busy, a_rdata); end
        a_req = 1'b0;
    endtask

    task automatic test_round_robin();
        logic          exp_b;
        logic [AW-1:0] exp_addr;
        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h10; a_wdata = 16'hAAAA;
        b_req = 1'b1; b_we = 1'b1; b_addr = 6'h20; b_wdata = 16'hBBBB;
        for (int g = 0; g < 4; g++) begin
            exp_b    = (g % 2) == 1;
            exp_addr = exp_b ? 6'h20 : 6'h10;
            tick();
            checks++;
            if ({mem_we, mem_addr} !== {1'b1, exp_addr}) begin failures++;
                $display("FAIL rr_grant%0d: got we=%b addr=%h expected 1 %h", g, mem_we, mem_addr, exp_addr); end
            tick(); tick();
            checks++;
            if ({a_ack, b_ack} !== {~exp_b, exp_b}) begin failures++;
                $display("FAIL rr_ack%0d: got a/b=%b%b expected %b%b", g, a_ack, b_ack, ~exp_b, exp_b); end
            tick();
            checks++;
            if (busy !== 1'b0) begin failures++;
                $display("FAIL rr_idle%0d: got busy=%b expected 0", g, busy); end
        end
        a_req = 1'b0; b_req = 1'b0;
        checks++;
        if ({mem[16], mem[32]} !== {16'hAAAA, 16'hBBBB}) begin failures++;
            $display("FAIL rr_mem: got %h %h expected AAAA BBBB", mem[16], mem[32]); end
        tick();
    endtask

    task automatic test_latched_inputs();
        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h3F; a_wdata = 16'hBEEF;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h11; b_wdata = 16'h0000;
        tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'h3F, 16'hBEEF}) begin failures++;
            $display("FAIL lat_a_access: got we=%b addr=%h wdata=%h expected 1 3f beef", mem_we, mem_addr, mem_wdata); end
        a_addr = 6'h00; a_wdata = 16'h0000; a_we = 1'b0; b_addr = 6'h3F;
        tick();
        checks++;
        if (mem_addr !== 6'h3F) begin failures++;
            $display("FAIL lat_a_wait: got addr=%h expected 3f", mem_addr); end
        tick();
        checks++;
        if ({a_ack, b_ack} !== 2'b10) begin failures++;
            $display("FAIL lat_a_done: got a/b=%b%b expected 10", a_ack, b_ack); end
        tick();
        checks++;
        if (mem[63] !== 16'hBEEF) begin failures++;
            $display("FAIL lat_a_mem: got %h expected beef", mem[63]); end
        a_req = 1'b0;
        tick();
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 6'h3F}) begin failures++;
            $display("FAIL lat_b_access: got we=%b addr=%h expected 0 3f", mem_we, mem_addr); end
        b_addr = 6'h00;
        tick();
        checks++;
        if (mem_addr !== 6'h3F) begin failures++;
            $display("FAIL lat_b_wait: got addr=%h expected 3f", mem_addr); end
        tick();
        checks++;
        if ({a_ack, b_ack, b_rdata} !== {2'b01, 16'hBEEF}) begin failures++;
            $display("FAIL lat_b_done: got a/b=%b%b rdata=%h expected 01 beef", a_ack, b_ack, b_rdata); end
        tick();
        b_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h05;
        tick();
        checks++;
        if ({busy, mem_addr} !== {1'b1, 6'h05}) begin failures++;
            $display("FAIL rstmid_access: got busy=%b addr=%h expected 1 05", busy, mem_addr); end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, a_ack, b_ack, mem_we, mem_addr, mem_wdata, a_rdata, b_rdata} !== '0) begin failures++;
            $display("FAIL rstmid_outputs: got busy=%b ack=%b%b we=%b addr=%h wd=%h rd=%h/%h expected all 0",
                     busy, a_ack, b_ack, mem_we, mem_addr, mem_wdata, a_rdata, b_rdata); end
        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h10;
        tick();
        checks++;
        if ({mem_addr, b_ack} !== {6'h10, 1'b0}) begin failures++;
            $display("FAIL rstmid_tie: got addr=%h b_ack=%b expected 10 0", mem_addr, b_ack); end
        tick(); tick();
        checks++;
        if ({a_ack, b_ack, a_rdata} !== {2'b10, 16'hAAAA}) begin failures++;
            $display("FAIL rstmid_a_done: got a/b=%b%b rdata=%h expected 10 aaaa", a_ack, b_ack, a_rdata); end
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_during_write();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h3F; a_wdata = 16'h5A5A;
        tick();
        checks++;
        if ({mem_we, mem_addr} !== {1'b1, 6'h3F}) begin failures++;
            $display("FAIL rstwr_access: got we=%b addr=%h expected 1 3f", mem_we, mem_addr); end
        rst = 1'b1;
        tick();
        checks++;
        if ({a_ack, busy, mem_we} !== 3'b000) begin failures++;
            $display("FAIL rstwr_outputs: got a_ack/busy/we=%b expected 000", {a_ack, busy, mem_we}); end
        checks++;
        if (mem[63] !== 16'h5A5A) begin failures++;
            $display("FAIL rstwr_mem: got %h expected 5a5a", mem[63]); end
        rst = 1'b0; a_req = 1'b0;
        tick(); tick();
        checks++;
        if ({a_ack, b_ack, busy} !== 3'b000) begin failures++;
            $display("FAIL rstwr_no_ack: got a_ack/b_ack/busy=%b expected 000", {a_ack, b_ack, busy}); end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_latched_inputs();
        test_reset_mid_read();
        test_reset_during_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: memory data width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports a_req / b_req, input, 1: access request from CPU port (A) / IO port (B), held until acked.
REQ-006 SHALL have ports a_we / b_we, input, 1: 1 = write, 0 = read; valid while req high.
REQ-007 SHALL have ports a_addr / b_addr, input, ADDR_WIDTH: access address.
REQ-008 SHALL have ports a_wdata / b_wdata, input, DATA_WIDTH: write data.
REQ-009 SHALL have ports a_ack / b_ack, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports a_rdata / b_rdata, output, DATA_WIDTH: read result, valid with ack.
REQ-011 SHALL have ports mem_we, mem_addr, mem_wdata, output, 1 / ADDR_WIDTH / DATA_WIDTH: single-port memory command.
REQ-012 SHALL have port mem_q, input, DATA_WIDTH: memory read data, valid one cycle after the address is presented.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> WAIT -> DONE -> IDLE, one cycle per non-IDLE state.
REQ-015 In IDLE with at least one req high, SHALL latch the winner's we, addr and wdata plus the owner id, then go to ACCESS; with no req, SHALL stay in IDLE.
REQ-016 SHALL drive mem_we, mem_addr and mem_wdata from registers; mem_we is high only during ACCESS and only for a write.
REQ-017 In WAIT, SHALL sample mem_q into the owner's rdata register on the edge into DONE, for reads only; on writes, rdata holds its previous value.
REQ-018 SHALL assert the owner's ack, registered, for exactly the DONE cycle; the other ack stays 0.
REQ-019 Latency: req sampled in IDLE cycle n gives ACCESS in n+1, WAIT in n+2, ack in n+3; peak throughput is one access per 4 cycles.
REQ-020 Handshake: transfer completes on the edge where req and ack are both high; the requester may drop or change req/we/addr/wdata only after that edge.
REQ-021 Changes to req/we/addr/wdata while not acked SHALL be ignored after latching; the latched values are used.
REQ-022 Arbitration SHALL be two-way round-robin: if only one req is high, it wins; if both are high, the port not served last wins.
REQ-023 The last-served pointer SHALL update only in DONE.
REQ-024 The requester acked in DONE, if it re-requests immediately, SHALL lose to a pending other requester in the following IDLE.
REQ-025 ADDR and DATA SHALL pass through unmodified; no address wrap or translation; full ADDR_WIDTH range is legal.
REQ-026 rdata registers SHALL hold their value until the next read completion for that port.

Reset
REQ-027 On rst high at a clock edge: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, a_ack/b_ack 0, a_rdata/b_rdata 0, busy 0, last-served pointer = B (so A wins the first tie).
REQ-028 If rst is asserted mid-transaction, SHALL abandon the transaction with no ack.
REQ-029 A write whose ACCESS cycle coincides with rst still commits in memory, because memory samples mem_we that edge; the bench SHALL treat this as defined behaviour.
REQ-030 rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, ACCESS, WAIT, DONE) and the owner id encoding (OWN_A = 0, OWN_B = 1).
REQ-032 The 2-way round-robin pick SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output grant id, valid), combinational.
REQ-033 The FSM and registers SHALL remain in mem_arbiter.

Verification
REQ-034 Reset, then A write addr 0x05 data 0x1234, B idle -> mem_we high in cycle n+1 only with mem_addr 0x05; a_ack pulse at n+3; b_ack stays 0.
REQ-035 A read addr 0x05 after the write above, with memory model 1-cycle latency -> a_rdata = 0x1234 with a_ack at n+3; busy high for n+1..n+3.
REQ-036 A and B request simultaneously right after reset, both held -> A served first, then B; next tie goes to A again; grants alternate A,B,A,B.
REQ-037 A write in flight to addr 0x3F; B changes b_addr while waiting -> B's access uses its address as sampled at its grant; A's addr 0x3F is unaffected.
REQ-038 rst pulsed during WAIT of a B read -> no b_ack; all outputs 0 next cycle; a subsequent tie is won by A.
REQ-039 A write to addr 0x3F with rst during ACCESS -> memory holds the data; no ack issued.
